// File: rtl/stream_extrema_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_extrema_tracker_if
// Purpose  : Sample stream bundle (valid/ready/data) feeding the extrema
//            tracker.
// Ports    : in_valid - producer has a sample on in_data
//            in_ready - consumer can accept a sample this cycle
//            in_data  - unsigned sample, WIDTH bits
// Modports : master - sample producer
//            slave  - sample consumer (the tracker)
// Revision : 1.0 - initial release
// ============================================================================
interface stream_extrema_tracker_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/stream_extrema_tracker.sv
`default_nettype none
// ============================================================================
// Module   : stream_extrema_tracker
// Purpose  : Collects a frame of N_SAMPLES unsigned samples over a
//            valid/ready stream and reports the largest and smallest value of
//            the frame together with their (earliest) acceptance indices.
// Ports    : clk       - rising-edge clock
//            rst_n     - asynchronous active-low reset
//            s_if      - sample stream (slave modport)
//            start_i   - frame start, honoured in IDLE or REPORT only
//            busy_o    - high while a frame is being collected
//            done_o    - one-cycle pulse after the last sample is accepted
//            max_val_o - largest sample of the last completed frame
//            min_val_o - smallest sample of the last completed frame
//            max_idx_o - index of max_val_o within that frame
//            min_idx_o - index of min_val_o within that frame
// Revision : 1.0 - initial release
// ============================================================================
module stream_extrema_tracker #(
    parameter int WIDTH     = 8,
    parameter int N_SAMPLES = 8,
    parameter int IDX_W     = $clog2(N_SAMPLES)
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    stream_extrema_tracker_if.slave s_if,
    input  wire logic               start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [WIDTH-1:0]        max_val_o,
    output logic [WIDTH-1:0]        min_val_o,
    output logic [IDX_W-1:0]        max_idx_o,
    output logic [IDX_W-1:0]        min_idx_o
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_SAMPLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

    // Unsigned magnitude compare scanned from MSB to LSB: the first differing
    // bit decides. Equal operands fall through as "not greater", which is what
    // makes ties keep the earliest index.
    function automatic logic mag_gt(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b);
        logic decided;
        logic gt;
        decided = 1'b0;
        gt      = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!decided && (a[i] != b[i])) begin
                decided = 1'b1;
                gt      = a[i];
            end
        end
        return gt;
    endfunction

    state_t           state_q,    state_d;
    logic [IDX_W-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0] run_max_q,  run_max_d;
    logic [WIDTH-1:0] run_min_q,  run_min_d;
    logic [IDX_W-1:0] run_maxi_q, run_maxi_d;
    logic [IDX_W-1:0] run_mini_q, run_mini_d;
    logic [WIDTH-1:0] max_val_q,  max_val_d;
    logic [WIDTH-1:0] min_val_q,  min_val_d;
    logic [IDX_W-1:0] max_idx_q,  max_idx_d;
    logic [IDX_W-1:0] min_idx_q,  min_idx_d;
    logic             done_q,     done_d;

    logic             w_collect;
    logic             w_accept;
    logic             w_new_max;
    logic             w_new_min;
    // Running extrema including the sample accepted this cycle
    logic [WIDTH-1:0] w_max;
    logic [WIDTH-1:0] w_min;
    logic [IDX_W-1:0] w_maxi;
    logic [IDX_W-1:0] w_mini;

    assign w_collect     = (state_q == ST_COLLECT);
    assign s_if.in_ready = w_collect;
    assign w_accept      = s_if.in_valid && w_collect;

    assign w_new_max = mag_gt(s_if.in_data, run_max_q);
    assign w_new_min = mag_gt(run_min_q, s_if.in_data);

    always_comb begin
        w_max  = run_max_q;
        w_min  = run_min_q;
        w_maxi = run_maxi_q;
        w_mini = run_mini_q;
        if (cnt_q == '0) begin
            // First sample seeds both running extrema
            w_max  = s_if.in_data;
            w_min  = s_if.in_data;
            w_maxi = '0;
            w_mini = '0;
        end else begin
            if (w_new_max) begin
                w_max  = s_if.in_data;
                w_maxi = cnt_q;
            end
            if (w_new_min) begin
                w_min  = s_if.in_data;
                w_mini = cnt_q;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        run_max_d  = run_max_q;
        run_min_d  = run_min_q;
        run_maxi_d = run_maxi_q;
        run_mini_d = run_mini_q;
        max_val_d  = max_val_q;
        min_val_d  = min_val_q;
        max_idx_d  = max_idx_q;
        min_idx_d  = min_idx_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_REPORT: begin
                if (start_i) begin
                    state_d    = ST_COLLECT;
                    cnt_d      = '0;
                    run_max_d  = '0;
                    run_min_d  = '0;
                    run_maxi_d = '0;
                    run_mini_d = '0;
                end
            end
            ST_COLLECT: begin
                if (w_accept) begin
                    run_max_d  = w_max;
                    run_min_d  = w_min;
                    run_maxi_d = w_maxi;
                    run_mini_d = w_mini;
                    if (cnt_q == c_LAST_IDX) begin
                        // Publish results at the same edge as the last sample
                        state_d   = ST_REPORT;
                        max_val_d = w_max;
                        min_val_d = w_min;
                        max_idx_d = w_maxi;
                        min_idx_d = w_mini;
                        done_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            run_max_q  <= '0;
            run_min_q  <= '0;
            run_maxi_q <= '0;
            run_mini_q <= '0;
            max_val_q  <= '0;
            min_val_q  <= '0;
            max_idx_q  <= '0;
            min_idx_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            run_max_q  <= run_max_d;
            run_min_q  <= run_min_d;
            run_maxi_q <= run_maxi_d;
            run_mini_q <= run_mini_d;
            max_val_q  <= max_val_d;
            min_val_q  <= min_val_d;
            max_idx_q  <= max_idx_d;
            min_idx_q  <= min_idx_d;
            done_q     <= done_d;
        end
    end

    assign busy_o    = w_collect;
    assign done_o    = done_q;
    assign max_val_o = max_val_q;
    assign min_val_o = min_val_q;
    assign max_idx_o = max_idx_q;
    assign min_idx_o = min_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_extrema_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_extrema_tracker
// Purpose  : Self-checking bench for stream_extrema_tracker. A driver issues
//            directed frames and pushes the hand-computed frame result into a
//            queue; a monitor pops and compares whenever done is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_extrema_tracker;

    localparam int c_WIDTH = 8;
    localparam int c_N     = 8;
    localparam int c_IDX_W = 3;

    typedef struct packed {
        logic [7:0] mx;
        logic [7:0] mn;
        logic [2:0] mxi;
        logic [2:0] mni;
    } exp_t;

    logic clk;
    logic rst_n;
    logic start;
    logic busy;
    logic done;
    logic [c_WIDTH-1:0] max_val;
    logic [c_WIDTH-1:0] min_val;
    logic [c_IDX_W-1:0] max_idx;
    logic [c_IDX_W-1:0] min_idx;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];

    stream_extrema_tracker_if #(.WIDTH(c_WIDTH)) u_if ();

    stream_extrema_tracker #(
        .WIDTH    (c_WIDTH),
        .N_SAMPLES(c_N),
        .IDX_W    (c_IDX_W)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_if     (u_if),
        .start_i  (start),
        .busy_o   (busy),
        .done_o   (done),
        .max_val_o(max_val),
        .min_val_o(min_val),
        .max_idx_o(max_idx),
        .min_idx_o(min_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("max_val", 32'(max_val), 32'(e.mx));
                chk("min_val", 32'(min_val), 32'(e.mn));
                chk("max_idx", 32'(max_idx), 32'(e.mxi));
                chk("min_idx", 32'(min_idx), 32'(e.mni));
            end
        end
    end

    // Drive one sample after 'gap' idle cycles; returns with time at #1 past
    // the accepting edge.
    task automatic send(input logic [7:0] d, input int gap, input logic st);
        bit ok;
        for (int g = 0; g < gap; g++) begin
            u_if.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        u_if.in_valid = 1'b1;
        u_if.in_data  = d;
        start         = st;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (u_if.in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        if (!ok) chk("ready_timeout", 32'd0, 32'd1);
        u_if.in_valid = 1'b0;
        start         = 1'b0;
    endtask

    // Start a frame and send n_send samples (sample 0 in the top byte).
    // A full frame pushes its expected result just before the last sample.
    // mid_start >= 0 pulses start together with that sample and checks that
    // the previous results stay published.
    task automatic run_frame(input logic [63:0] data, input logic [31:0] gaps,
                             input int n_send, input int mid_start,
                             input exp_t e, input exp_t prev);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ready_after_start", 32'(u_if.in_ready), 32'd1);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("done_low_after_start", 32'(done), 32'd0);
        for (int i = 0; i < n_send; i++) begin
            if (i == c_N - 1) exp_q.push_back(e);
            send(data[63-8*i -: 8], int'(gaps[31-4*i -: 4]), (i == mid_start));
            if (i == mid_start) begin
                chk("busy_held", 32'(busy), 32'd1);
                chk("prev_max_held", 32'(max_val), 32'(prev.mx));
                chk("prev_min_held", 32'(min_val), 32'(prev.mn));
            end
        end
        if (n_send == c_N) begin
            chk("done_latency", 32'(done), 32'd1);
            chk("ready_in_report", 32'(u_if.in_ready), 32'd0);
            chk("busy_in_report", 32'(busy), 32'd0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready"}, 32'(u_if.in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_outs"}, {max_val, min_val, 5'd0, max_idx, min_idx}, 32'd0);
    endtask

    exp_t e_asc, e_gap, e_eq, e_ign, e_msb, e_bnd, e_zero;

    initial begin
        e_zero = '{mx: 8'h00, mn: 8'h00, mxi: 3'd0, mni: 3'd0};
        e_asc  = '{mx: 8'd80,  mn: 8'd10,  mxi: 3'd7, mni: 3'd0};
        e_gap  = '{mx: 8'd255, mn: 8'd0,   mxi: 3'd6, mni: 3'd7};
        e_eq   = '{mx: 8'h55,  mn: 8'h55,  mxi: 3'd0, mni: 3'd0};
        e_ign  = '{mx: 8'd30,  mn: 8'd1,   mxi: 3'd4, mni: 3'd5};
        e_msb  = '{mx: 8'h80,  mn: 8'h7F,  mxi: 3'd1, mni: 3'd0};
        e_bnd  = '{mx: 8'hFF,  mn: 8'h00,  mxi: 3'd2, mni: 3'd1};

        rst_n         = 1'b0;
        start         = 1'b0;
        u_if.in_valid = 1'b0;
        u_if.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", 32'(u_if.in_ready), 32'd0);

        // Ascending 10..80, no gaps
        run_frame(64'h0A141E28323C4650, 32'h0, 8, -1, e_asc, e_zero);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);

        // 5,200,7,200,3,3,255,0 with valid gaps of 0..3 cycles
        run_frame(64'h05C807C80303FF00, 32'h01230312, 8, -1, e_gap, e_asc);
        repeat (2) @(posedge clk); #1;

        // All-equal frame: earliest tie index wins
        run_frame(64'h5555555555555555, 32'h10101010, 8, -1, e_eq, e_gap);
        @(posedge clk); #1;

        // start pulsed with sample 3 is ignored; previous results held
        run_frame(64'h09040C041E011E02, 32'h0, 8, 3, e_ign, e_eq);
        @(posedge clk); #1;

        // Reset after 4 samples: partial frame discarded, no done
        run_frame(64'h1122334455667788, 32'h0, 4, -1, e_zero, e_ign);
        rst_n = 1'b0;
        #2;
        check_reset_state("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("midrst_idle_ready", 32'(u_if.in_ready), 32'd0);

        // MSB-only difference: 0x80 > 0x7F
        run_frame(64'h7F807F807F7F7F7F, 32'h01000100, 8, -1, e_msb, e_zero);
        // Back-to-back: start issued in the done cycle, boundary values
        run_frame(64'h8000FF7FFF00807F, 32'h0, 8, -1, e_bnd, e_msb);
        repeat (4) @(posedge clk); #1;

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/stream_extrema_tracker.md
Name: stream_extrema_tracker

Overview:
- Downstream consumer of the cascaded magnitude-compare stage.
- Accepts a frame of N unsigned samples over a valid/ready handshake.
- Per accepted sample, compares it against the running maximum and running minimum (EQ/GT semantics, MSB-first, unsigned).
- At end of frame, reports max/min values and their indices with a one-cycle done pulse.

Parameters:
- WIDTH, 8, sample width in bits; compares are unsigned.
- N_SAMPLES, 8, samples per frame; legal range 2..256.
- IDX_W, $clog2(N_SAMPLES), width of the sample counter and index outputs.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  frame start request; honoured only in IDLE or REPORT.
- in_valid  input  1  sample present on in_data.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  WIDTH  unsigned sample.
- busy  output  1  high while in COLLECT.
- done  output  1  one-cycle pulse when the frame completes.
- max_val  output  WIDTH  largest sample of the last completed frame.
- min_val  output  WIDTH  smallest sample of the last completed frame.
- max_idx  output  IDX_W  index (0-based, acceptance order) of max_val.
- min_idx  output  IDX_W  index of min_val.

Behaviour:
- Reset (async assert, sync-to-clock deassert effect): state=IDLE.
  - in_ready=0, busy=0, done=0.
  - max_val=0, min_val=0, max_idx=0, min_idx=0.
  - Sample counter=0.
- States: IDLE, COLLECT, REPORT.
- Transitions:
  - IDLE --start--> COLLECT
  - COLLECT --Nth accepted sample--> REPORT
  - REPORT --start--> COLLECT
  - No other transitions.
- Start handling:
  - start in COLLECT is ignored; the frame continues unaffected.
  - Entering COLLECT clears the sample counter and the internal running registers.
  - Published outputs (max_val/min_val/idx) keep the previous frame's results until the next frame completes.
- Handshake:
  - in_ready=1 exactly when state==COLLECT (combinational from state).
  - A sample is accepted iff in_valid && in_ready on a rising edge.
  - in_valid may drop at any time; idle cycles do not advance the counter.
- Accepting sample k (k = counter value at acceptance):
  - k==0: running max=min=in_data; both running indices=0.
  - k>0: if in_data GT running max (strict), update max and max index to k.
  - k>0: if running min GT in_data (strict), update min and min index to k.
  - Ties keep the earliest index.
  - One sample may update both max and min only when k==0.
- Compare rule: unsigned magnitude, scanned MSB to LSB. The first differing bit decides; all bits equal gives EQ. Implemented combinationally in the same cycle as acceptance; no extra latency.
- Frame completion: on the cycle the sample with k==N_SAMPLES-1 is accepted, the final max/min (including that sample) are registered into the output registers at that edge.
  - Next cycle: state=REPORT, done=1 for exactly one cycle, busy=0, in_ready=0.
  - Latency from last acceptance to done = 1 cycle.
- Back-to-back frames: start asserted during the done cycle moves to COLLECT on the following edge. in_ready rises one cycle after done.
- Counter: IDX_W bits; never wraps inside a frame because completion occurs at N_SAMPLES-1.
- Reset mid-frame: partial frame discarded, all outputs return to reset values, done not emitted.
- Outputs are registered; no combinational path from in_data to any output.

Test Plan:
- Ascending frame 10,20,...,80 after start -> done 1 cycle after the 8th acceptance; max_val=80, max_idx=7, min_val=10, min_idx=0.
- Frame 5,200,7,200,3,3,255,0 with in_valid gaps of 0-3 cycles -> max_val=255/idx 6, min_val=0/idx 7. Counter advances only on handshakes; done occurs exactly once.
- All-equal frame of 8×0x55 -> max_val=min_val=0x55, max_idx=min_idx=0 (earliest tie kept).
- start pulsed at sample 3 of a COLLECT frame -> ignored. The frame completes after 8 acceptances with correct results, and previous-frame outputs are held until then.
- rst_n low for 1 cycle after 4 samples -> all outputs 0, state IDLE, in_ready=0, no done. A new start then runs a clean frame.
- Boundary values 0x00 and 0xFF plus MSB-only difference pair 0x80 vs 0x7F -> max_val=0xFF, min_val=0x00, and 0x80 is treated as greater than 0x7F.
